// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO register pair.
//   The core stalls on busy while an operation is in flight. mfhi/mflo read hi/lo
//   directly, and mthi/mtlo write them in one cycle without raising busy.
//
//   Optional feature: define FAST_MUL_EN to compute MULT/MULTU with one
//   combinational multiply (IDLE -> FIX, busy for a single cycle). When the macro
//   is undefined, the multiplier is iterative and no '*' operator is synthesized.
//
// Ports
//   clk       in   core clock, rising edge
//   rst       in   synchronous active-high reset
//   op_valid  in   operation request this cycle
//   op_code   in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_val    in   multiplicand / dividend / mthi-mtlo data
//   rt_val    in   multiplier / divisor
//   abort     in   exception flush; cancels the in-flight operation
//   busy      out  high while an operation is in flight
//   done      out  one-cycle pulse; HI/LO are updated on the same edge
//   div_zero  out  one-cycle pulse with done when the divisor was zero
//   hi, lo    out  HI and LO registers
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;       // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
  logic [CNT_W-1:0]     cnt;
  logic                 is_div;
  logic                 neg_res;   // negate product / quotient
  logic                 neg_rem;   // remainder takes the dividend's sign
  logic                 dz;        // divisor was zero at request

  logic                 op_signed;
  logic [WIDTH-1:0]     rs_mag;
  logic [WIDTH-1:0]     rt_mag;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;

  // Magnitude of a two's-complement value when the operation is signed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    return (sgn && sv < 0) ? WIDTH'(-sv) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_p(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    op_signed = (op_code == 3'd0) || (op_code == 3'd2);
    rs_mag    = mag(rs_val, op_signed);
    rt_mag    = mag(rt_val, op_signed);

    // Shift-add step: conditionally add the multiplicand to the upper half, then
    // shift the whole accumulator right, consuming one multiplier bit.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder, keep the
    // trial difference only when it does not go negative.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    div_ge    = div_shift >= {1'b0, opnd};
    div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    prod_fix  = cond_neg_p(acc, neg_res);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (abort) begin
        // Flush: drop whatever is in flight (or being requested) without touching HI/LO.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (op_valid) begin
              case (op_code)
                3'd0, 3'd1: begin
                  is_div  <= 1'b0;
                  neg_res <= op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_rem <= 1'b0;
                  dz      <= 1'b0;
                  cnt     <= '0;
                  opnd    <= rs_mag;
                  busy    <= 1'b1;
`ifdef FAST_MUL_EN
                  acc     <= {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
                  state   <= S_FIX;
`else
                  acc     <= {{WIDTH{1'b0}}, rt_mag};
                  state   <= S_MUL;
`endif
                end
                3'd2, 3'd3: begin
                  is_div  <= 1'b1;
                  neg_res <= op_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_rem <= op_signed & rs_val[WIDTH-1];
                  dz      <= (rt_val == '0);
                  cnt     <= '0;
                  acc     <= {{WIDTH{1'b0}}, rs_mag};
                  opnd    <= rt_mag;
                  busy    <= 1'b1;
                  state   <= S_DIV;
                end
                3'd4:    hi <= rs_val;
                3'd5:    lo <= rs_val;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            acc <= mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
          S_DIV: begin
            acc <= div_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
          S_FIX: begin
            // Sign correction and result write-back
            if (is_div) begin
              // With a zero divisor the remainder path ends up holding the
              // dividend itself, so only LO needs forcing.
              lo       <= dz ? {WIDTH{1'b1}} : cond_neg_w(acc[WIDTH-1:0], neg_res);
              hi       <= cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
              div_zero <= dz;
            end else begin
              lo <= prod_fix[WIDTH-1:0];
              hi <= prod_fix[2*WIDTH-1:WIDTH];
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Testbench for hilo_muldiv_sequencer: directed cases plus randomized operations
// compared against an arithmetic reference model of HI/LO.
module tb_hilo_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        abort;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  hilo_muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural operation.
  task automatic model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] up;
    sa  = int'(a);
    sb  = int'(b);
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    case (code)
      3'd0: begin sp = longint'(sa) * longint'(sb); {eh, el} = sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; {eh, el} = up; end
      3'd2: begin
        if (b == 0) begin el = '1; eh = a; edz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = '0; end
        else begin el = sa / sb; eh = sa % sb; end
      end
      default: begin
        if (b == 0) begin el = '1; eh = a; edz = 1'b1; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  // Issue one request at a negedge and check its outcome. intrude raises a
  // spurious op_valid during busy cycle 5, which the sequencer must ignore.
  task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input bit intrude);
    int          nbusy;
    int          guard;
    int          exp_lat;
    logic [31:0] eh;
    logic [31:0] el;
    logic        edz;
    op_code  = code;
    rs_val   = a;
    rt_val   = b;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    if (code >= 3'd4) begin
      if (code == 3'd4) mhi = a;
      if (code == 3'd5) mlo = a;
      check("mtx_busy", busy, 0);
      check("mtx_done", done, 0);
      check("mtx_hi", hi, mhi);
      check("mtx_lo", lo, mlo);
      return;
    end
    model(code, a, b, eh, el, edz);
`ifdef FAST_MUL_EN
    exp_lat = (code < 3'd2) ? 1 : 33;
`else
    exp_lat = 33;
`endif
    nbusy = 0;
    guard = 0;
    while (!done && guard < 100) begin
      if (busy) nbusy++;
      if (nbusy == 16) check("hold_hi", hi, mhi);
      op_valid = intrude && (nbusy == 5);
      if (op_valid) begin
        op_code = 3'd1;
        rs_val  = $urandom;
        rt_val  = $urandom;
      end
      guard++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    check("done_seen", done, 1);
    check("latency", nbusy, exp_lat);
    check("res_hi", hi, eh);
    check("res_lo", lo, el);
    check("div_zero", div_zero, edz);
    mhi = eh;
    mlo = el;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    op_code  = '0;
    rs_val   = '0;
    rt_val   = '0;
    abort    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);

    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd0, 32'hFFFF_FFF9, 32'd3, 1'b0);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd3, 32'd100, 32'd0, 1'b0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd4, 32'h1234, 32'd0, 1'b0);
    do_op(3'd5, 32'h5678, 32'd0, 1'b0);

    // abort together with a request in IDLE drops the request
    abort    = 1'b1;
    op_valid = 1'b1;
    op_code  = 3'd4;
    rs_val   = 32'hDEAD_BEEF;
    @(negedge clk);
    abort    = 1'b0;
    op_valid = 1'b0;
    check("abort_idle_hi", hi, mhi);
    check("abort_idle_busy", busy, 0);

    // abort during busy cycle 10 of a DIVU
    op_code  = 3'd3;
    rs_val   = 32'd10;
    rt_val   = 32'd3;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, mhi);
    check("abort_lo", lo, mlo);
    do_op(3'd3, 32'd10, 32'd3, 1'b0);

    // reset during busy cycle 20 of a MULT
    op_code  = 3'd0;
    rs_val   = $urandom;
    rt_val   = $urandom;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mhi = '0;
    mlo = '0;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);

    // request during an in-flight DIV must not disturb it
    do_op(3'd2, 32'hFFFF_F000, 32'd7, 1'b1);

    for (int i = 0; i < 25; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
